fetch_queue: RTL
================

# fetch_queue

Parametrised instruction-fetch front end for the MIPS core. It replaces the bare PC register / PC+4 / PC-select path with an owned fetch PC and a synchronous-read instruction memory request port. Fetched words go into a DEPTH-entry prefetch FIFO, which drives decode through a valid/ready handshake. Branch and jump targets arrive as a single redirect that flushes all speculative fetch state.

## Interface
Parameters:
- ADDR_W, 32: PC and memory address width in bits; legal range 8..32.
- DEPTH, 4: prefetch FIFO entries; minimum 2, and must be a power of two.
- RESET_PC, 0: fetch address after reset; must be word-aligned.

Ports (clock and reset first):
- clk  input  1  the single clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-high.
- imem_req  output  1  request a read of the word at imem_addr in this cycle.
- imem_addr  output  ADDR_W  byte address of the requested word; bits [1:0] are always 0.
- imem_rdata  input  32  read data; valid exactly 1 cycle after the cycle in which imem_req=1.
- redirect  input  1  taken branch or jump; load redirect_pc and flush.
- redirect_pc  input  ADDR_W  new fetch address; bits [1:0] are ignored and treated as 0.
- out_valid  output  1  FIFO head is valid.
- out_ready  input  1  decode accepts the head this cycle.
- out_instr  output  32  instruction at the FIFO head.
- out_pc  output  ADDR_W  address of out_instr.
- out_pc_plus4  output  ADDR_W  out_pc+4, modulo 2^ADDR_W.
- count  output  $clog2(DEPTH+1)  number of valid FIFO entries.

## Operation
Internal state:
- fetch_pc: next address to request.
- inflight: 1-bit flag plus its PC tag, marking an outstanding request.
- FIFO storage of {instr, pc}, with read pointer, write pointer and count.

Request issue:
- imem_addr = fetch_pc at all times.
- pop = out_valid & out_ready.
- imem_req = !reset & !redirect & (count + inflight - pop < DEPTH).
- When a request issues: fetch_pc <= fetch_pc + 4, wrapping modulo 2^ADDR_W; inflight <= 1; tag <= fetch_pc.
- When no request issues: inflight <= 0.

Response:
- When inflight=1 and no redirect is asserted this cycle, {imem_rdata, tag} is pushed into the FIFO.
- The FIFO cannot overflow because of the issue rule. An attempted overflow is a bug and must be flagged by a bench assertion.

Output:
- out_* reflects the FIFO head combinationally from registered storage.
- out_valid = (count != 0).
- A pop advances the read pointer.
- A push and a pop in the same cycle leave count unchanged.

Redirect (has priority over everything except reset):
- FIFO is emptied: count <= 0 and both pointers are reset.
- inflight <= 0, so the response arriving this cycle is discarded.
- fetch_pc <= redirect_pc with bits [1:0] forced to 0.
- No request is issued in the redirect cycle.
- If out_valid & out_ready also hold in the redirect cycle, that handshake completes: decode keeps the word. The flush takes effect after it.

Reset, checked at the clock edge while reset=1:
- fetch_pc <= RESET_PC.
- inflight <= 0.
- count <= 0 and both pointers are reset.
- Reset overrides redirect and any in-flight response.
- Output values during and immediately after reset: out_valid=0, count=0, imem_req=0, imem_addr=RESET_PC.
- FIFO data storage is not reset; its contents are don't-care while out_valid=0.

## Timing
- Cycle 0 is the first cycle with reset=0: imem_req=1 and imem_addr=RESET_PC.
- Cycle 1: response pushed; next request is for RESET_PC+4.
- Cycle 2: out_valid=1 with out_pc=RESET_PC. Fetch-to-output latency is 2 cycles.
- Throughput is 1 instruction per cycle while out_ready is held at 1, for any DEPTH >= 2.
- Redirect at cycle R: request to redirect_pc at R+1; out_valid=1 with out_pc=redirect_pc at R+3. Between the redirect and that output, out_valid=0 at R+1 and R+2.
- Back-to-back redirects: the last one wins, and each restarts the sequence above.
- Back-pressure: with out_ready=0, count saturates at DEPTH. The request stream stops once count + inflight = DEPTH, and no request is ever issued for an entry that has no free slot.
- Address wrap: the request after address 2^ADDR_W-4 is to address 0.

## Test plan
- Reset streaming: RESET_PC=0x40, out_ready held at 1, memory returns word = address. Required: out_pc = 0x40, 0x44, 0x48, … on consecutive cycles starting at cycle 2, and out_instr = out_pc.
- Back-pressure: out_ready=0 for 10 cycles, then 1. Required: count reaches 4 and stays there, imem_req drops to 0, and the drained stream has no gap and no duplicate PC.
- Redirect mid-stream to 0x1000 at cycle R. Required: out_valid=0 at R+1 and R+2; out_pc=0x1000 at R+3; no stale PC is ever output.
- Redirect while the FIFO is full, with out_ready=1 in the same cycle. Required: the head is accepted exactly once, count=0 at R+1, and the next output is redirect_pc.
- Wrap with ADDR_W=8: redirect to 0xF8. Required: output sequence 0xF8, 0xFC, 0x00, 0x04; out_pc_plus4 at 0xFC is 0x00.
- Reset asserted mid-stream for 1 cycle while inflight=1 and count=3. Required: the next cycle shows out_valid=0 and count=0; the first request is to RESET_PC; the discarded response never appears at the output.

Source files
------------

// File: rtl/fetch_queue.sv
// fetch_queue
// Instruction-fetch front end. It owns the fetch PC and issues one read per
// cycle to a synchronous-read instruction memory. Returned words are stored
// in a DEPTH-entry prefetch FIFO. That FIFO feeds decode through a
// valid/ready handshake. A redirect (a taken branch or a jump) reloads the
// fetch PC and discards all speculative fetch state.
//
// Ports:
//   clk_i            clock; all state updates happen on its rising edge
//   reset_i          synchronous, active-high reset
//   imem_req_o       read request for the word at imem_addr_o this cycle
//   imem_addr_o      word-aligned byte address of the request (the fetch PC)
//   imem_rdata_i     read data, returned one cycle after the request
//   redirect_i       load redirect_pc_i and flush all fetch state
//   redirect_pc_i    new fetch address; the low two bits are ignored
//   out_valid_o      the FIFO head holds an instruction
//   out_ready_i      decode accepts the head this cycle
//   out_instr_o      instruction at the FIFO head
//   out_pc_o         address of out_instr_o
//   out_pc_plus4_o   out_pc_o + 4, wrapping at the address width
//   count_o          number of valid FIFO entries

module fetch_queue #(
    parameter int unsigned       ADDR_W   = 32,
    parameter int unsigned       DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic                         clk_i,
    input  logic                         reset_i,
    output logic                         imem_req_o,
    output logic [ADDR_W-1:0]            imem_addr_o,
    input  logic [31:0]                  imem_rdata_i,
    input  logic                         redirect_i,
    input  logic [ADDR_W-1:0]            redirect_pc_i,
    output logic                         out_valid_o,
    input  logic                         out_ready_i,
    output logic [31:0]                  out_instr_o,
    output logic [ADDR_W-1:0]            out_pc_o,
    output logic [ADDR_W-1:0]            out_pc_plus4_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o
);

    localparam int unsigned       CNT_W   = $clog2(DEPTH + 1);
    localparam int unsigned       PTR_W   = $clog2(DEPTH);
    localparam logic [CNT_W:0]    DEPTH_L = (CNT_W + 1)'(DEPTH);

    // Reject parameter sets the pointer arithmetic cannot support.
    // Wrapping the pointers by natural overflow needs a power-of-two depth.
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || ADDR_W < 8 || ADDR_W > 32
        || RESET_PC[1:0] != 2'b00) begin : g_param_check
        $error("fetch_queue: illegal parameter combination");
    end

    logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
    logic              inflight_q, inflight_d;
    logic [ADDR_W-1:0] tag_q, tag_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;

    logic [31:0]       instr_mem [DEPTH];
    logic [ADDR_W-1:0] pc_mem    [DEPTH];

    logic              pop;
    logic              push;
    logic              issue;
    logic [CNT_W:0]    occupancy;

    // Handshake and request-issue decisions for this cycle.
    // The occupancy is the FIFO fill level the next response will see: the
    // current entries, plus the word now in flight, minus the head that decode
    // takes this cycle. A request issues only while that level leaves a free
    // slot, so the FIFO can never overflow.
    always_comb begin
        pop       = out_valid_o & out_ready_i;
        push      = inflight_q & ~redirect_i & ~reset_i;
        occupancy = {1'b0, count_q}
                  + {{CNT_W{1'b0}}, inflight_q}
                  - {{CNT_W{1'b0}}, pop};
        issue     = ~reset_i & ~redirect_i & (occupancy < DEPTH_L);
    end

    // Next-state logic for the fetch PC, the in-flight tracker and the FIFO
    // bookkeeping. A redirect is applied last, so it overrides normal
    // advancement. A pop in the redirect cycle still happens (decode keeps
    // that word), but the flush then discards the rest of the FIFO.
    always_comb begin
        fetch_pc_d = fetch_pc_q;
        tag_d      = tag_q;
        inflight_d = issue;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;

        if (issue) begin
            fetch_pc_d = fetch_pc_q + ADDR_W'(4);
            tag_d      = fetch_pc_q;
        end

        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end

        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        if (redirect_i) begin
            fetch_pc_d = redirect_pc_i & ~ADDR_W'(3);
            inflight_d = 1'b0;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            count_d    = '0;
        end
    end

    // Control state registers. Reset takes priority over a redirect and over
    // any response still in flight.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            fetch_pc_q <= RESET_PC;
            inflight_q <= 1'b0;
            tag_q      <= RESET_PC;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            inflight_q <= inflight_d;
            tag_q      <= tag_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
        end
    end

    // FIFO storage is not reset. The count decides which entries are
    // meaningful, so stale contents are never visible at the outputs.
    always_ff @(posedge clk_i) begin
        if (push) begin
            instr_mem[wr_ptr_q] <= imem_rdata_i;
            pc_mem[wr_ptr_q]    <= tag_q;
        end
    end

    // Outputs. The FIFO head is presented combinationally from the
    // registered storage.
    always_comb begin
        imem_req_o     = issue;
        imem_addr_o    = fetch_pc_q;
        out_valid_o    = (count_q != '0);
        out_instr_o    = instr_mem[rd_ptr_q];
        out_pc_o       = pc_mem[rd_ptr_q];
        out_pc_plus4_o = pc_mem[rd_ptr_q] + ADDR_W'(4);
        count_o        = count_q;
    end

endmodule
